// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : shared encodings for the memory-stage load/store unit       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_align : store lane replication/byte enables and load extraction   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] store_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (st_funct3)
      F3_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte  = rdata[{ld_off, 3'b000} +: 8];
    w_half  = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   ld_data = {24'd0, w_byte};
      F3_H:    ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   ld_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_lsu : MEM-stage load/store unit, req/ack bus with timeout   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int                 c_cnt_w    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  lsu_state_t         r_state, w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_is_load;
  logic [2:0]         r_f3;
  logic [1:0]         r_off;
  logic               w_access, w_illegal, w_misaligned, w_go;
  logic               w_ack, w_timeout, w_stall;
  logic [3:0]         w_st_be;
  logic [31:0]        w_st_wdata, w_ld_fmt;

  lsu_align u_align (
    .st_funct3  (funct3),
    .st_off     (addr[1:0]),
    .store_data (store_data),
    .st_be      (w_st_be),
    .st_wdata   (w_st_wdata),
    .ld_funct3  (r_f3),
    .ld_off     (r_off),
    .rdata      (bus_rdata),
    .ld_data    (w_ld_fmt)
  );

  always_comb begin
    w_access  = mem_read | mem_write;
    w_illegal = mem_read & mem_write;
    if (mem_read && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      w_illegal = 1'b1;
    if (mem_write && (funct3 > F3_W))
      w_illegal = 1'b1;
    w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                   ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    w_go      = w_access & ~w_illegal & ~w_misaligned;
    w_ack     = bus_ack & bus_req;
    w_timeout = (r_cnt == c_cnt_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_go;
        if (w_go) w_next = REQ;
      end
      REQ: begin
        w_stall = 1'b1;
        if (w_ack || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset forces stall low combinationally so the pipeline is not held while reset is asserted
  assign stall = w_stall & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      bus_err    <= 1'b0;
      r_cnt      <= '0;
      r_is_load  <= 1'b0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      bus_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          fault <= w_access & ~w_go;
          if (w_go) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= mem_write ? w_st_be : 4'b1111;
            bus_wdata <= w_st_wdata;
            r_is_load <= mem_read;
            r_f3      <= funct3;
            r_off     <= addr[1:0];
            r_cnt     <= '0;
          end
        end
        REQ: begin
          // An ack in the timeout cycle takes priority over the abort
          if (w_ack) begin
            bus_req <= 1'b0;
            r_cnt   <= '0;
            if (r_is_load) begin
              load_data  <= w_ld_fmt;
              load_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            r_cnt     <= '0;
            load_data <= 32'd0;
            bus_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
- Issues one aligned access per instruction to the data-memory bus using a req/ack handshake.
- Stalls the upstream pipeline while the access is outstanding.
- Returns the formatted load data: byte/halfword extracted, then sign- or zero-extended.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without ack before the access aborts with bus_err; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store; mem_read and mem_write both high is treated as a fault
- funct3  in  3  access size/signedness (RV32I load/store encoding)
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value, unaligned
- stall  out  1  combinational; the upstream register enable is !stall
- load_data  out  32  formatted load result, registered
- load_valid  out  1  one-cycle pulse; load_data updated this cycle
- fault  out  1  one-cycle pulse on misaligned address or illegal funct3
- bus_err  out  1  one-cycle pulse on timeout
- bus_req  out  1  registered request
- bus_we  out  1  registered write enable
- bus_addr  out  32  registered, word-aligned ({addr[31:2],2'b00})
- bus_be  out  4  registered byte enables
- bus_wdata  out  32  registered, lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completes the request; ignored unless bus_req is high

Behaviour:
- Reset (asynchronous): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, load_valid=0, fault=0, bus_err=0, timeout counter=0. Reset mid-REQ drops bus_req immediately; a late ack is ignored.
- access = mem_read | mem_write.
- illegal = funct3 in {011,110,111} for loads; funct3 > 010 for stores; or mem_read & mem_write.
- misaligned = (halfword & addr[0]) | (word & addr[1:0]!=0).
- IDLE:
  - If access & !illegal & !misaligned: register bus outputs, bus_req<=1, go to REQ.
  - If access & (illegal | misaligned): fault pulses next cycle; no bus activity; stay in IDLE.
  - stall = access & !illegal & !misaligned.
- REQ:
  - stall=1; bus_addr, bus_be, bus_wdata and bus_we are held stable.
  - On bus_ack: bus_req<=0, clear counter, go to DONE. For loads, load_data<=format(bus_rdata) and load_valid pulses in DONE.
  - Without ack: counter increments. When counter == TIMEOUT_CYCLES-1 with no ack: bus_req<=0, load_data<=0, bus_err pulses in DONE, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; there is no error.
- DONE: stall=0, so upstream advances at this edge. Next state is IDLE unconditionally, so the same instruction is never reissued.
- Latency: an access with ack in the first REQ cycle takes 3 cycles (IDLE, REQ, DONE). A non-memory instruction takes 0 stall cycles.
- Byte enables and write data:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{sd[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata={2{sd[15:0]}}.
  - SW: be=1111.
  - Loads: be=1111, we=0.
- Load format:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: halfword lane addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
- load_data holds its value until the next completed load. Stores and faults do not change it.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum lsu_state_t: IDLE, REQ, DONE.
  - Timeout counter width: $clog2(TIMEOUT_CYCLES).
- Sub-module lsu_align, purely combinational:
  - Store path: be and wdata generation from funct3, addr[1:0], store_data.
  - Load path: extraction and extension from funct3, addr[1:0], rdata.
  - Top level holds the FSM, counter and registers.

Test Plan:
- LW addr=0x100, ack in the first REQ cycle with rdata=0xDEADBEEF -> bus_addr=0x100, be=1111; stall high for 2 cycles; load_data=0xDEADBEEF with load_valid in DONE.
- LB addr=0x103, rdata=0x80FF1234 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SH addr=0x206, store_data=0x0000ABCD -> bus_we=1, be=1100, wdata=0xABCDABCD, bus_addr=0x204; load_data unchanged.
- LW addr=0x101 -> fault pulse, bus_req never asserts, stall=0. Same for SW with funct3=011.
- Load with no ack, TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, then bus_err pulse, load_data=0, stall released. Repeat with ack on the 4th cycle -> no bus_err.
- Reset asserted during REQ -> bus_req=0 and stall=0 the same cycle. An ack after reset release produces no load_valid.
